// File: rtl/counter_run_arbiter.sv
// Grants one counter "run" (load start, step len times, freeze) at a time among NREQ requesters.
// Optional build macro CNT_RUN_ARB_RR_EN selects round-robin arbitration; default is fixed priority (lowest index).
module counter_run_arbiter #(
  parameter int WIDTH = 4,
  parameter int NREQ  = 2,
  parameter int LEN_W = 8,
  localparam int ID_W = (NREQ <= 2) ? 1 : 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] req_start,
  input  logic [NREQ-1:0]       req_dir,
  input  logic [NREQ*LEN_W-1:0] req_len,
  output logic [NREQ-1:0]       grant,
  output logic                  done,
  output logic [ID_W-1:0]       done_id,
  output logic                  busy,
  output logic [WIDTH-1:0]      cnt_d,
  output logic                  cnt_load,
  output logic                  cnt_updown,
  input  logic [WIDTH-1:0]      cnt_q
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

  state_t           state;
  logic [ID_W-1:0]  win;
  logic [WIDTH-1:0] start_r;
  logic             dir_r;
  logic [LEN_W-1:0] len_r;
  logic [LEN_W-1:0] steps;
  logic [ID_W-1:0]  pick;

`ifdef CNT_RUN_ARB_RR_EN
  logic [ID_W-1:0] rr_ptr;
  int              idx;

  // Scan offsets high to low so the requester closest above rr_ptr is written last and wins.
  always_comb begin
    pick = '0;
    idx  = 0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      idx = int'(rr_ptr) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      if (req[idx]) pick = ID_W'(idx);
    end
  end
`else
  always_comb begin
    pick = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i]) pick = ID_W'(i);
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      win     <= '0;
      start_r <= '0;
      dir_r   <= 1'b1;
      len_r   <= '0;
      steps   <= '0;
`ifdef CNT_RUN_ARB_RR_EN
      rr_ptr  <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (|req) begin
            win     <= pick;
            start_r <= req_start[int'(pick)*WIDTH +: WIDTH];
            dir_r   <= req_dir[pick];
            len_r   <= req_len[int'(pick)*LEN_W +: LEN_W];
            state   <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (len_r == '0) begin
            state <= S_DONE;
          end else begin
            steps <= len_r;
            state <= S_RUN;
          end
        end
        S_RUN: begin
          steps <= steps - LEN_W'(1);
          if (steps == LEN_W'(1)) state <= S_DONE;
        end
        S_DONE: begin
          state <= S_IDLE;
`ifdef CNT_RUN_ARB_RR_EN
          rr_ptr <= (int'(win) == NREQ - 1) ? '0 : win + 1'b1;
`endif
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Outside LOAD/RUN the counter reloads its own value, i.e. it is frozen.
  always_comb begin
    grant      = '0;
    done       = 1'b0;
    done_id    = '0;
    busy       = 1'b0;
    cnt_load   = 1'b1;
    cnt_d      = cnt_q;
    cnt_updown = 1'b1;
    case (state)
      S_LOAD: begin
        cnt_d      = start_r;
        cnt_updown = dir_r;
        grant[win] = 1'b1;
        busy       = 1'b1;
      end
      S_RUN: begin
        cnt_load   = 1'b0;
        cnt_updown = dir_r;
        grant[win] = 1'b1;
        busy       = 1'b1;
      end
      S_DONE: begin
        done       = 1'b1;
        done_id    = win;
        grant[win] = 1'b1;
        busy       = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_counter_run_arbiter.sv
// Bench for counter_run_arbiter with a behavioural loadable up/down counter on cnt_d/cnt_load/cnt_updown/cnt_q.
module tb_counter_run_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] req = '0;
  logic [7:0] req_start = '0;
  logic [1:0] req_dir = '0;
  logic [15:0] req_len = '0;
  logic [1:0] grant;
  logic       done;
  logic       done_id;
  logic       busy;
  logic [3:0] cnt_d;
  logic       cnt_load;
  logic       cnt_updown;
  logic [3:0] count = 4'd0;

  int total = 0;
  int bad   = 0;

  counter_run_arbiter #(.WIDTH(4), .NREQ(2), .LEN_W(8)) dut (
    .clk(clk), .rst(rst), .req(req), .req_start(req_start), .req_dir(req_dir),
    .req_len(req_len), .grant(grant), .done(done), .done_id(done_id), .busy(busy),
    .cnt_d(cnt_d), .cnt_load(cnt_load), .cnt_updown(cnt_updown), .cnt_q(count)
  );

  // clock / reset block and the free-running counter model
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (cnt_load) count <= cnt_d;
    else if (cnt_updown) count <= count + 4'd1;
    else count <= count - 4'd1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, required $finish earlier");
    $fatal(1, "watchdog");
  end

  always @(negedge clk) begin
    total++;
    if ($countones(grant) > 1) begin
      bad++;
      $display("FAIL grant_onehot: got %b required at most one bit", grant);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [1:0] r;
    logic [3:0] s0, s1;
    logic [1:0] d;
    logic [7:0] l0, l1;
    logic       id;
    logic [3:0] start;
    logic [3:0] cnt;
    int         len;
  } vec_t;

  vec_t vecs[6];

  // Driver: present one request, then follow it through LOAD/RUN/DONE.
  task automatic do_run(input vec_t v);
    int cyc;
    int runs;
    req       = v.r;
    req_start = {v.s1, v.s0};
    req_dir   = v.d;
    req_len   = {v.l1, v.l0};
    tick();
    check("load_busy", busy, 1);
    check("load_grant", grant, 2'b01 << v.id);
    check("load_d", cnt_d, v.start);
    check("load_ld", cnt_load, 1);
    req  = '0;
    cyc  = 0;
    runs = 0;
    while (!done && cyc < 300) begin
      if (!cnt_load) runs++;
      tick();
      cyc++;
    end
    check("done_seen", done, 1);
    check("done_latency", cyc, v.len + 1);
    check("run_cycles", runs, v.len);
    check("done_id", done_id, v.id);
    check("done_count", count, v.cnt);
    check("done_grant", grant, 2'b01 << v.id);
    tick();
    check("after_done", done, 0);
    check("after_busy", busy, 0);
  endtask

  logic [4:0] exp_q[$];
  logic [4:0] exp_e;
  int cyc;

  initial begin
    vecs[0] = '{r:2'b01, s0:4'd9,  s1:4'd0, d:2'b01, l0:8'd5, l1:8'd0,  id:1'b0, start:4'd9,  cnt:4'd14, len:5};
    vecs[1] = '{r:2'b01, s0:4'd14, s1:4'd0, d:2'b01, l0:8'd3, l1:8'd0,  id:1'b0, start:4'd14, cnt:4'd1,  len:3};
    vecs[2] = '{r:2'b10, s0:4'd0,  s1:4'd1, d:2'b00, l0:8'd0, l1:8'd3,  id:1'b1, start:4'd1,  cnt:4'd14, len:3};
    vecs[3] = '{r:2'b01, s0:4'd6,  s1:4'd0, d:2'b01, l0:8'd0, l1:8'd0,  id:1'b0, start:4'd6,  cnt:4'd6,  len:0};
    vecs[4] = '{r:2'b10, s0:4'd0,  s1:4'd0, d:2'b00, l0:8'd0, l1:8'd1,  id:1'b1, start:4'd0,  cnt:4'd15, len:1};
    vecs[5] = '{r:2'b10, s0:4'd0,  s1:4'd3, d:2'b10, l0:8'd0, l1:8'd16, id:1'b1, start:4'd3,  cnt:4'd3,  len:16};

    #1;
    check("rst_grant", grant, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_done_id", done_id, 0);
    check("rst_load", cnt_load, 1);
    check("rst_updown", cnt_updown, 1);
    check("rst_d", cnt_d, 0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("idle_count", count, 0);

    for (int i = 0; i < 6; i++) do_run(vecs[i]);

    // Run ending at 14, then a long idle stretch: counter must stay frozen.
    do_run(vecs[0]);
    for (int i = 0; i < 20; i++) begin
      tick();
      check("idle_hold_count", count, 14);
      check("idle_hold_load", cnt_load, 1);
      check("idle_hold_busy", busy, 0);
    end

    // Both requesters held high, len=2 each; reset first so arbitration starts fresh.
    rst = 1'b1;
    tick();
    rst = 1'b0;
`ifdef CNT_RUN_ARB_RR_EN
    exp_q.push_back({1'b0, 4'd2});
    exp_q.push_back({1'b1, 4'd10});
    exp_q.push_back({1'b0, 4'd2});
    exp_q.push_back({1'b1, 4'd10});
`else
    exp_q.push_back({1'b0, 4'd2});
    exp_q.push_back({1'b0, 4'd2});
    exp_q.push_back({1'b0, 4'd2});
`endif
    req       = 2'b11;
    req_start = {4'd8, 4'd0};
    req_dir   = 2'b11;
    req_len   = {8'd2, 8'd2};
    cyc = 0;
    while (exp_q.size() > 0 && cyc < 100) begin
      tick();
      cyc++;
      if (done) begin
        exp_e = exp_q.pop_front();
        check("hold_done_id", done_id, exp_e[4]);
        check("hold_count", count, exp_e[3:0]);
      end
    end
    check("hold_all_done", exp_q.size(), 0);
    req = '0;
    cyc = 0;
    while (busy && cyc < 50) begin
      tick();
      cyc++;
    end
    check("hold_idle", busy, 0);

    // Reset asserted mid-run with three steps left, count at 4.
    req       = 2'b01;
    req_start = {4'd0, 4'd2};
    req_dir   = 2'b01;
    req_len   = {8'd0, 8'd5};
    tick();
    req = '0;
    tick();
    tick();
    tick();
    check("mid_run_busy", busy, 1);
    check("mid_run_load", cnt_load, 0);
    check("mid_run_count", count, 4);
    rst = 1'b1;
    #1;
    check("arst_grant", grant, 0);
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_load", cnt_load, 1);
    tick();
    check("arst_hold", count, 4);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("post_rst_count", count, 4);
      check("post_rst_load", cnt_load, 1);
      check("post_rst_busy", busy, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
